alu_issue_ctrl: RTL

//   Sequential front-end for the team's combinational ALU. Accepts one operation per

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: func encodings, FSM state type and default datapath width.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_EQ   = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_FUNC_MAX = ALU_SRA;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and alu_issue_ctrl (slave).
//   req_*   : operation request, valid/ready
//   acc_clr : accumulator clear strobe (requester side)
//   rsp_*   : registered result, valid/ready
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_func;
  logic             req_acc;
  logic             acc_clr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_of;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_func, req_acc, acc_clr, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_of, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_func, req_acc, acc_clr, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_of, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational team ALU.
//   a_i, b_i : operands (shift amount is b_i[4:0])
//   func_i   : operation code (alu_pkg ALU_*)
//   y_o      : result; of_o signed overflow (add/sub only); err_o illegal func
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       func_i,
  output logic [WIDTH-1:0] y_o,
  output logic             of_o,
  output logic             err_o
);
  logic [4:0]       shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sa, sb;

  assign shamt = b_i[4:0];
  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign sa    = a_i[WIDTH-1];
  assign sb    = b_i[WIDTH-1];

  always_comb begin
    y_o   = '0;
    of_o  = 1'b0;
    err_o = 1'b0;
    case (func_i)
      ALU_ADD: begin
        y_o  = sum;
        of_o = (sa == sb) && (sum[WIDTH-1] != sa);
      end
      ALU_SUB: begin
        y_o  = diff;
        of_o = (sa != sb) && (diff[WIDTH-1] != sa);
      end
      ALU_EQ:   y_o = {{(WIDTH-1){1'b0}}, a_i == b_i};
      ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, a_i < b_i};
      ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRA:  y_o = $signed(a_i) >>> shamt;
      default:  err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front-end for the combinational ALU: registers a request, runs it through
// the ALU for one cycle, and holds the registered result until the consumer takes it.
// Also keeps a chaining accumulator, a sticky overflow flag and a handoff counter.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response handshake (slave side)
//   sticky_of : OR of all overflows since reset
//   op_count  : number of completed response handoffs, wraps
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_ctrl_if.slave    bus,
  output logic               sticky_of,
  output logic [CNT_W-1:0]   op_count
);
  state_t           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, acc_q, rsp_y_q;
  logic [WIDTH-1:0] op_a_d;
  logic [3:0]       func_q;
  logic             rsp_valid_q, rsp_of_q, rsp_err_q, sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_of, alu_err;

  // A clear arriving with an accumulator request wins, so the op sees zero.
  always_comb begin
    op_a_d = bus.req_a;
    if (bus.req_acc) op_a_d = bus.acc_clr ? '0 : acc_q;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .func_i(func_q),
    .y_o   (alu_y),
    .of_o  (alu_of),
    .err_o (alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      func_q      <= ALU_ADD;
      acc_q       <= '0;
      rsp_y_q     <= '0;
      rsp_of_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.acc_clr) acc_q <= '0;
          if (bus.req_valid) begin
            op_a_q  <= op_a_d;
            op_b_q  <= bus.req_b;
            func_q  <= bus.req_func;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_of_q    <= alu_of;
          rsp_err_q   <= alu_err;
          rsp_valid_q <= 1'b1;
          acc_q       <= alu_y;
          sticky_q    <= sticky_q | alu_of;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_of    = rsp_of_q;
  assign bus.rsp_err   = rsp_err_q;
  assign sticky_of     = sticky_q;
  assign op_count      = cnt_q;
endmodule
